// File: rtl/eq_band_scheduler.sv
// Weighted band summer: one shared multiplier walks NUM_BANDS samples, the sum is saturated to DATA_W.
// Latency: out_valid rises NUM_BANDS edges after accept. Backpressure: result held in OUTPUT until out_ready; in_ready only in IDLE.
// Shadow/active gain banks; a commit lands on an IDLE cycle so a sample never sees mixed gain sets.
module eq_band_scheduler #(
    parameter int DATA_W    = 10,
    parameter int GAIN_W    = 10,
    parameter int GAIN_FRAC = 8,
    parameter int NUM_BANDS = 10,
    parameter int ADDR_W    = $clog2(NUM_BANDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BANDS*DATA_W-1:0] band_in,
    input  logic                        gain_wr_en,
    input  logic [ADDR_W-1:0]           gain_wr_addr,
    input  logic [GAIN_W-1:0]           gain_wr_data,
    input  logic                        gain_commit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           data_out_gain,
    output logic                        sat_flag,
    output logic                        busy
);
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t state, state_nxt;

    logic [NUM_BANDS*DATA_W-1:0] band_q;
    logic [GAIN_W-1:0]           shadow [NUM_BANDS];
    logic [GAIN_W-1:0]           active [NUM_BANDS];
    logic                        commit_pending;
    logic [ADDR_W-1:0]           idx;
    logic signed [ACC_W-1:0]     acc, acc_nxt, shifted;
    logic signed [DATA_W-1:0]    cur_band;
    logic signed [GAIN_W:0]      cur_gain;
    logic signed [PROD_W:0]      prod;
    logic [DATA_W-1:0]           sat_val;
    logic                        sat_hit;
    logic                        last;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign last     = (idx == ADDR_W'(NUM_BANDS - 1));

    // Gain is zero-extended so the multiply stays signed without reinterpreting the top gain bit.
    always_comb begin
        cur_band = band_q[idx*DATA_W +: DATA_W];
        cur_gain = {1'b0, active[idx]};
        prod     = cur_band * cur_gain;
        acc_nxt  = acc + ACC_W'(prod);
        shifted  = acc_nxt >>> GAIN_FRAC;
        sat_hit  = 1'b0;
        sat_val  = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_hit = 1'b1;
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_hit = 1'b1;
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last)      state_nxt = OUTPUT;
            OUTPUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            band_q        <= '0;
            acc           <= '0;
            idx           <= '0;
            out_valid     <= 1'b0;
            data_out_gain <= '0;
            sat_flag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        band_q <= band_in;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    if (last) begin
                        data_out_gain <= sat_val;
                        sat_flag      <= sat_hit;
                        out_valid     <= 1'b1;
                    end
                end
                OUTPUT: if (out_ready) out_valid <= 1'b0;
                default: out_valid <= 1'b0;
            endcase
        end
    end

    // The active copy reads shadow before this edge's write, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow[b] <= '0;
                active[b] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (gain_commit || commit_pending) begin
                    active         <= shadow;
                    commit_pending <= 1'b0;
                end
            end else if (gain_commit) begin
                commit_pending <= 1'b1;
            end
            if (gain_wr_en && (int'(gain_wr_addr) < NUM_BANDS))
                shadow[gain_wr_addr] <= gain_wr_data;
        end
    end
endmodule

// File: tb/tb_eq_band_scheduler.sv
// Randomized scoreboard bench for eq_band_scheduler against a transaction-level gain/sum model.
module tb_eq_band_scheduler;
    localparam int DW = 10;
    localparam int GW = 10;
    localparam int GF = 8;
    localparam int NB = 10;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [NB*DW-1:0] band_in = '0;
    logic           gain_wr_en = 1'b0;
    logic [AW-1:0]  gain_wr_addr = '0;
    logic [GW-1:0]  gain_wr_data = '0;
    logic           gain_commit = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  data_out_gain;
    logic           sat_flag;
    logic           busy;

    eq_band_scheduler #(.DATA_W(DW), .GAIN_W(GW), .GAIN_FRAC(GF), .NUM_BANDS(NB), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .band_in(band_in),
        .gain_wr_en(gain_wr_en), .gain_wr_addr(gain_wr_addr), .gain_wr_data(gain_wr_data),
        .gain_commit(gain_commit), .out_valid(out_valid), .out_ready(out_ready),
        .data_out_gain(data_out_gain), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { int data; bit sat; } exp_t;
    exp_t exp_q[$];

    int  m_shadow [NB];
    int  m_active [NB];
    bit  m_pending = 1'b0;
    bit  m_idle = 1'b1;
    int  m_cnt = 0;
    int  accepts = 0;
    bit  rnd = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_result(input logic [NB*DW-1:0] bands);
        exp_t r;
        int sum = 0;
        logic signed [DW-1:0] bv;
        for (int b = 0; b < NB; b++) begin
            bv = bands[b*DW +: DW];
            sum += int'(bv) * m_active[b];
        end
        sum = sum >>> GF;
        r.sat = 1'b0;
        r.data = sum;
        if (sum > 511)  begin r.data = 511;  r.sat = 1'b1; end
        if (sum < -512) begin r.data = -512; r.sat = 1'b1; end
        return r;
    endfunction

    // Transaction-level model: idle/busy with a countdown to the result, gains as integer arrays.
    initial begin
        for (int b = 0; b < NB; b++) begin m_shadow[b] = 0; m_active[b] = 0; end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int b = 0; b < NB; b++) begin m_shadow[b] = 0; m_active[b] = 0; end
                m_pending = 1'b0;
                m_idle = 1'b1;
                m_cnt = 0;
                exp_q.delete();
            end else begin
                if (m_idle) begin
                    if (gain_commit || m_pending) begin
                        m_active = m_shadow;
                        m_pending = 1'b0;
                    end
                    if (in_valid) begin
                        exp_q.push_back(ref_result(band_in));
                        m_idle = 1'b0;
                        m_cnt = NB;
                        accepts++;
                    end
                end else begin
                    if (gain_commit) m_pending = 1'b1;
                    if (m_cnt > 0) m_cnt--;
                    else if (out_ready) m_idle = 1'b1;
                end
                if (gain_wr_en && int'(gain_wr_addr) < NB) m_shadow[gain_wr_addr] = int'(gain_wr_data);
            end
        end
    end

    // Monitor: handshake status every cycle, results popped from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("in_ready", int'(in_ready), int'(m_idle));
                chk("busy", int'(busy), int'(!m_idle));
                chk("out_valid", int'(out_valid), int'(!m_idle && m_cnt == 0));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        chk("data_out_gain", int'($signed(data_out_gain)), exp_q[0].data);
                        chk("sat_flag", int'(sat_flag), int'(exp_q[0].sat));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) begin
                out_ready    = ($urandom_range(0, 3) != 0);
                gain_wr_en   = ($urandom_range(0, 3) == 0);
                gain_wr_addr = AW'($urandom_range(0, 15));
                gain_wr_data = GW'($urandom_range(0, 300));
                gain_commit  = ($urandom_range(0, 7) == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_gain(input int a, input int d);
        gain_wr_en = 1'b1; gain_wr_addr = AW'(a); gain_wr_data = GW'(d);
        tick(1);
        gain_wr_en = 1'b0;
    endtask

    task automatic commit();
        gain_commit = 1'b1;
        tick(1);
        gain_commit = 1'b0;
    endtask

    function automatic logic [NB*DW-1:0] fill(input int v);
        logic [NB*DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [NB*DW-1:0] rand_bands();
        logic [NB*DW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic send(input logic [NB*DW-1:0] bands);
        int start = accepts;
        int t = 0;
        band_in = bands;
        in_valid = 1'b1;
        while (accepts == start && t < 300) begin tick(1); t++; end
        if (accepts == start) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        band_in = rand_bands();
    endtask

    task automatic drain();
        int t = 0;
        while (!(m_idle && exp_q.size() == 0) && t < 500) begin tick(1); t++; end
        if (!(m_idle && exp_q.size() == 0)) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [NB*DW-1:0] bv;
        tick(3);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data", int'(data_out_gain), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        tick(2);

        send(fill(100));                      // muted gains -> 0
        drain();

        wr_gain(0, 256);
        commit();
        bv = fill(50);
        bv[DW-1:0] = DW'(100);
        send(bv);
        tick(9);
        chk("latency_early", int'(out_valid), 0);
        tick(1);
        chk("latency_exact", int'(out_valid), 1);
        drain();

        for (int b = 0; b < NB; b++) wr_gain(b, 256);
        commit();
        send(fill(100));
        drain();
        send(fill(-100));
        drain();
        for (int b = 0; b < NB; b++) wr_gain(b, (b == 3) ? 128 : 0);
        commit();
        bv = rand_bands();
        bv[3*DW +: DW] = DW'(-3);
        send(bv);
        drain();

        out_ready = 1'b0;                     // backpressure hold
        send(rand_bands());
        tick(NB);
        in_valid = 1'b1;
        tick(5);
        chk("hold_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(1);
        chk("release_idle", int'(in_ready), 1);
        drain();

        for (int b = 0; b < NB; b++) wr_gain(b, 0);
        commit();
        bv = fill(0);
        bv[DW +: DW] = DW'(10);
        send(bv);
        wr_gain(1, 512);
        wr_gain(12, 77);
        commit();
        drain();
        bv = rand_bands();
        bv[DW +: DW] = DW'(10);
        send(bv);
        drain();

        wr_gain(0, 256);                      // reset mid-flight with a pending commit
        send(fill(100));
        tick(3);
        commit();
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b1;
        tick(15);
        wr_gain(0, 256);
        send(fill(100));
        drain();

        rnd = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(rand_bands());
            tick($urandom_range(0, 14));
        end
        rnd = 1'b0;
        gain_wr_en = 1'b0;
        gain_commit = 1'b0;
        out_ready = 1'b1;
        drain();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
